// File: rtl/mme_pkg.sv
// Shared definitions for the matrix-multiply-engine tile: default
// array geometry, sequencer state encoding and a width helper.
package mme_pkg;

  localparam int SIZE_DEFAULT      = 4;
  localparam int DRAIN_LAT_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_FEED,
    ST_DRAIN,
    ST_WB,
    ST_DONE
  } mme_state_e;

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mme_ctrl_if.sv
// Datapath-side channels of the tile sequencer: data-provider control,
// array control and the result-row valid/ready channel.
interface mme_ctrl_if #(
  parameter int SIZE = mme_pkg::SIZE_DEFAULT
) ();

  localparam int ROW_W = mme_pkg::idx_width(SIZE);

  logic [7:0]       dp_width_o;
  logic             dp_start_o;
  logic             dp_a_done_i;
  logic             dp_b_done_i;
  logic             acc_clear_o;
  logic             mac_en_o;
  logic             wb_valid_o;
  logic [ROW_W-1:0] wb_row_o;
  logic             wb_ready_i;

  // Sequencer side.
  modport master (
    output dp_width_o, dp_start_o, acc_clear_o, mac_en_o, wb_valid_o, wb_row_o,
    input  dp_a_done_i, dp_b_done_i, wb_ready_i
  );

  // Provider / array / output-buffer side.
  modport slave (
    input  dp_width_o, dp_start_o, acc_clear_o, mac_en_o, wb_valid_o, wb_row_o,
    output dp_a_done_i, dp_b_done_i, wb_ready_i
  );

endinterface

// File: rtl/mme_ctrl.sv
// Tile-operation sequencer: launches both data providers, keeps the
// array enabled through feed and drain, writes back SIZE result rows
// and signals completion with a one-cycle done pulse.
module mme_ctrl
  import mme_pkg::*;
#(
  parameter int SIZE      = SIZE_DEFAULT,
  parameter int DRAIN_LAT = DRAIN_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  matrix_width_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  mme_ctrl_if.master  dp
);

  localparam int CNT_MAX = (DRAIN_LAT > SIZE) ? DRAIN_LAT : SIZE;
  localparam int CNT_W   = idx_width(CNT_MAX);
  localparam int ROW_W   = idx_width(SIZE);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAT - 1);
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(SIZE - 1);

  mme_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       width_reg, width_next;
  logic             err_reg, err_next;

  // State, shared counter, latched K and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      width_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      width_reg <= width_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and counter logic; the counter returns to 0 on every state exit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    width_next = width_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          if (matrix_width_i != 8'd0) begin
            width_next = matrix_width_i;
            state_next = ST_LAUNCH;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_next   = '0;
        state_next = ST_FEED;
      end
      ST_FEED: begin
        // Done levels are still high from idle in the first FEED cycle;
        // counter value 1 marks that the first cycle has passed.
        if (cnt_reg == '0) begin
          cnt_next = CNT_W'(1);
        end else if (dp.dp_a_done_i && dp.dp_b_done_i) begin
          cnt_next   = '0;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = ST_WB;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WB: begin
        if (dp.wb_ready_i) begin
          if (cnt_reg == ROW_LAST) begin
            cnt_next   = '0;
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy_o = (state_reg != ST_IDLE);
  assign done_o = (state_reg == ST_DONE);
  assign err_o  = err_reg;

  assign dp.dp_width_o  = width_reg;
  assign dp.dp_start_o  = (state_reg == ST_LAUNCH);
  assign dp.acc_clear_o = (state_reg == ST_LAUNCH);
  assign dp.mac_en_o    = (state_reg == ST_FEED) || (state_reg == ST_DRAIN);
  assign dp.wb_valid_o  = (state_reg == ST_WB);
  assign dp.wb_row_o    = (state_reg == ST_WB) ? cnt_reg[ROW_W-1:0] : '0;

endmodule

// File: tb/tb_mme_ctrl.sv
// Directed bench for mme_ctrl with behavioural data providers and an
// event scoreboard keyed on cycle number.
module tb_mme_ctrl;
  import mme_pkg::*;

  localparam int SIZE      = 4;
  localparam int DRAIN_LAT = 4;

  localparam logic [2:0] EV_LAUNCH = 3'd1;
  localparam logic [2:0] EV_MACON  = 3'd2;
  localparam logic [2:0] EV_MACOFF = 3'd3;
  localparam logic [2:0] EV_ROW    = 3'd4;
  localparam logic [2:0] EV_DONE   = 3'd5;
  localparam logic [2:0] EV_ERR    = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] cyc;
    logic [7:0]  val;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic [7:0] matrix_width;
  logic       busy, done, err;

  mme_ctrl_if #(.SIZE(SIZE)) bus ();

  mme_ctrl #(.SIZE(SIZE), .DRAIN_LAT(DRAIN_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .matrix_width_i (matrix_width),
    .start_i        (start_i),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .dp             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard providers: idle-high done, busy K+SIZE-1 cycles after start;
  // B can be held busy for b_extra further cycles.
  int a_cnt = 0;
  int b_cnt = 0;
  int b_extra = 0;
  always @(posedge clk) begin
    if (bus.dp_start_o === 1'b1) begin
      a_cnt <= int'(bus.dp_width_o) + SIZE - 1;
      b_cnt <= int'(bus.dp_width_o) + SIZE - 1 + b_extra;
    end else begin
      if (a_cnt > 0) a_cnt <= a_cnt - 1;
      if (b_cnt > 0) b_cnt <= b_cnt - 1;
    end
  end
  assign bus.dp_a_done_i = (a_cnt == 0);
  assign bus.dp_b_done_i = (b_cnt == 0);

  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_from = -1;
  int   stall_to = -1;
  logic mon_en = 1'b0;
  logic prev_mac = 1'b0;
  int   t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = 16'(c);
    e.val  = 8'(v);
    sb.push_back(e);
  endtask

  // Expected event stream of one full operation started in cycle s.
  task automatic push_op(input int s, input int k, input int extra, input int stall_len);
    int c;
    push(EV_LAUNCH, s + 1, 1);
    push(EV_MACON, s + 2, 0);
    c = s + 2 + k + SIZE + extra + DRAIN_LAT;
    push(EV_MACOFF, c, 0);
    for (int r = 0; r < SIZE; r++) begin
      if (r == 2) c += stall_len;
      push(EV_ROW, c, r);
      c++;
    end
    push(EV_DONE, c, 0);
  endtask

  task automatic expect_ev(input logic [2:0] kind, input int v);
    ev_t got, exp;
    got.kind = kind;
    got.cyc  = 16'(cyc);
    got.val  = 8'(v);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("sb_event", 32'(got), 32'(exp));
    end
  endtask

  task automatic monitor();
    if (mon_en) begin
      if (bus.dp_start_o === 1'b1) expect_ev(EV_LAUNCH, int'(bus.acc_clear_o));
      if (bus.mac_en_o === 1'b1 && prev_mac !== 1'b1) expect_ev(EV_MACON, 0);
      if (bus.mac_en_o !== 1'b1 && prev_mac === 1'b1) expect_ev(EV_MACOFF, 0);
      prev_mac = bus.mac_en_o;
      if (bus.wb_valid_o === 1'b1 && bus.wb_ready_i === 1'b1) expect_ev(EV_ROW, int'(bus.wb_row_o));
      if (done === 1'b1) expect_ev(EV_DONE, 0);
      if (err === 1'b1) expect_ev(EV_ERR, 0);
      if (cyc >= stall_from && cyc < stall_to)
        chk("stall_hold", 32'({bus.wb_valid_o, bus.wb_row_o}), 32'({1'b1, 2'd2}));
    end
  endtask

  // One cycle: drive ready, sample, advance to just after the next edge.
  task automatic step();
    bus.wb_ready_i = !(cyc >= stall_from && cyc < stall_to);
    #1;
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
    chk({tag, "_start"}, 32'(bus.dp_start_o), 32'd0);
    chk({tag, "_clear"}, 32'(bus.acc_clear_o), 32'd0);
    chk({tag, "_mac"},   32'(bus.mac_en_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.wb_valid_o), 32'd0);
    chk({tag, "_row"},   32'(bus.wb_row_o), 32'd0);
    chk({tag, "_width"}, 32'(bus.dp_width_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    matrix_width = 8'd0;
    bus.wb_ready_i = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    chk_idle_outputs("reset");
    mon_en = 1'b1;
    prev_mac = 1'b0;

    // Baseline K=4: launch 1, mac 2..13, rows 14..17, done 18.
    t0 = cyc;
    matrix_width = 8'd4;
    push_op(t0, 4, 0, 0);
    start_i = 1'b1;
    step();
    chk("busy_launch", 32'(busy), 32'd1);
    chk("width_latched", 32'(bus.dp_width_o), 32'd4);
    run_to(t0 + 18);
    chk("busy_done_cycle", 32'(busy), 32'd1);
    step();
    chk("busy_after_done", 32'(busy), 32'd0);
    run_to(t0 + 21);

    // Ready low three cycles on row 2: done moves to cycle 21.
    t0 = cyc;
    stall_from = t0 + 16;
    stall_to = t0 + 19;
    push_op(t0, 4, 0, 3);
    start_i = 1'b1;
    step();
    run_to(t0 + 24);
    stall_from = -1;
    stall_to = -1;

    // K=0 is rejected with an error pulse and no launch.
    t0 = cyc;
    matrix_width = 8'd0;
    push(EV_ERR, t0 + 1, 0);
    start_i = 1'b1;
    step();
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_no_start", 32'(bus.dp_start_o), 32'd0);
    chk("err_width_kept", 32'(bus.dp_width_o), 32'd4);
    run_to(t0 + 4);

    // Provider B finishes 5 cycles after A: done 5 cycles later.
    t0 = cyc;
    matrix_width = 8'd4;
    b_extra = 5;
    push_op(t0, 4, 5, 0);
    start_i = 1'b1;
    step();
    run_to(t0 + 26);
    b_extra = 0;

    // Starts in FEED and DONE ignored; restart right after DONE with K=7.
    t0 = cyc;
    matrix_width = 8'd4;
    push_op(t0, 4, 0, 0);
    push_op(t0 + 19, 7, 0, 0);
    start_i = 1'b1;
    step();
    run_to(t0 + 5);
    matrix_width = 8'd9;
    start_i = 1'b1;
    step();
    chk("feed_start_ignored_width", 32'(bus.dp_width_o), 32'd4);
    chk("feed_start_busy", 32'(busy), 32'd1);
    run_to(t0 + 18);
    start_i = 1'b1;
    step();
    chk("done_start_ignored_width", 32'(bus.dp_width_o), 32'd4);
    matrix_width = 8'd7;
    start_i = 1'b1;
    step();
    chk("restart_width", 32'(bus.dp_width_o), 32'd7);
    run_to(t0 + 42);

    // Reset during DRAIN aborts with no done; mac drops the next cycle.
    t0 = cyc;
    matrix_width = 8'd4;
    push(EV_LAUNCH, t0 + 1, 1);
    push(EV_MACON, t0 + 2, 0);
    push(EV_MACOFF, t0 + 12, 0);
    start_i = 1'b1;
    step();
    run_to(t0 + 11);
    chk("drain_mac", 32'(bus.mac_en_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("abort");
    run_to(t0 + 25);

    // Normal operation after the abort, K=3: done in cycle 17.
    t0 = cyc;
    matrix_width = 8'd3;
    push_op(t0, 3, 0, 0);
    start_i = 1'b1;
    step();
    run_to(t0 + 20);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
